// File: rtl/intpol2_d4_pkg.sv
// intpol2_d4_pkg: op codes, default lane geometry and lane-slice helper shared by the add/sub pipe.
package intpol2_d4_pkg;
    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int N_BITS_DEF = 2;
    localparam int W_DEF = DATA_WIDTH_DEF + N_BITS_DEF;
    localparam logic [W_DEF-1:0] SAT_MAX = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic [W_DEF-1:0] SAT_MIN = {1'b1, {(W_DEF-1){1'b0}}};
    function automatic int lane_lo(input int i, input int w);
        return i * w;
    endfunction
endpackage

// File: rtl/intpol2_d4_addsub_if.sv
// intpol2_d4_addsub_if: shared valid/ready beat bus carrying all lanes' operands and results.
interface intpol2_d4_addsub_if #(
    parameter int W = 34,
    parameter int N_CH = 4
);
    logic s_valid;
    logic s_ready;
    logic [N_CH-1:0] op;
    logic [N_CH*W-1:0] A;
    logic [N_CH*W-1:0] B;
    logic m_valid;
    logic m_ready;
    logic [N_CH*W-1:0] C;
    logic [N_CH-1:0] ovf;
    modport master (output s_valid, op, A, B, m_ready, input s_ready, m_valid, C, ovf);
    modport slave (input s_valid, op, A, B, m_ready, output s_ready, m_valid, C, ovf);
endinterface

// File: rtl/intpol2_d4_addsub_lane.sv
// intpol2_d4_addsub_lane: one lane of W+1-bit signed add/sub with optional clamp to the W-bit range.
module intpol2_d4_addsub_lane import intpol2_d4_pkg::*; #(
    parameter int W = 34,
    parameter bit SAT_EN = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic [W-1:0] c,
    output logic         ovf_hit
);
    logic [W:0] sum;
    always_comb begin
        sum = (op == OP_ADD) ? {a[W-1], a} + {b[W-1], b} : {a[W-1], a} - {b[W-1], b};
        ovf_hit = sum[W] ^ sum[W-1];
        c = (ovf_hit && SAT_EN) ? (sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sum[W-1:0];
    end
endmodule

// File: rtl/intpol2_d4_addsub_pipe.sv
// intpol2_d4_addsub_pipe: two-stage, N_CH-lane add/sub pipe with shared valid/ready handshake,
// global enable and sticky per-lane overflow flags.
module intpol2_d4_addsub_pipe import intpol2_d4_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_bits = N_BITS_DEF,
    parameter int N_CH = 4,
    parameter int SAT_EN = 1
) (
    input logic clk,
    input logic rst,
    input logic en,
    input logic clr_ovf,
    intpol2_d4_addsub_if.slave bus
);
    localparam int W = DATA_WIDTH + N_bits;
    logic v1_q, v1_d, v2_q, v2_d;
    logic [N_CH*W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, res;
    logic [N_CH-1:0] op_q, op_d, ovf_q, ovf_d, hit;
    logic adv1, adv2, ld1, upd;
    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        intpol2_d4_addsub_lane #(.W(W), .SAT_EN(SAT_EN != 0)) u_lane (
            .a(a_q[lane_lo(i, W) +: W]),
            .b(b_q[lane_lo(i, W) +: W]),
            .op(op_q[i]),
            .c(res[lane_lo(i, W) +: W]),
            .ovf_hit(hit[i])
        );
    end
    always_comb begin
        adv2 = en && (!v2_q || bus.m_ready);
        adv1 = en && (!v1_q || adv2);
        ld1 = adv1 && bus.s_valid;
        upd = adv2 && v1_q;
        v1_d = adv1 ? bus.s_valid : v1_q;
        a_d = ld1 ? bus.A : a_q;
        b_d = ld1 ? bus.B : b_q;
        op_d = ld1 ? bus.op : op_q;
        v2_d = adv2 ? v1_q : v2_q;
        c_d = upd ? res : c_q;
        // a fresh overflow in the clearing cycle must survive the clear
        ovf_d = en ? ((clr_ovf ? '0 : ovf_q) | (upd ? hit : '0)) : ovf_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            c_q <= '0;
            ovf_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            a_q <= a_d;
            b_q <= b_d;
            op_q <= op_d;
            c_q <= c_d;
            ovf_q <= ovf_d;
        end
    end
    assign bus.s_ready = adv1 && !rst;
    assign bus.m_valid = v2_q;
    assign bus.C = c_q;
    assign bus.ovf = ovf_q;
endmodule
